// File: rtl/apb_mem_param.sv
// APB slave scratch RAM: configurable width, depth and wait states, with error response for out-of-range words.
// Define APB_MEM_STRB_EN to add the Pstrb byte-write-strobe port; without it every write updates the full word.
module apb_mem_param #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    Pclk,
    input  logic                    Prst,
    input  logic                    Pselx,
    input  logic                    Penable,
    input  logic                    Pwrite,
    input  logic [ADDR_WIDTH-1:0]   Paddr,
    input  logic [DATA_WIDTH-1:0]   Pwdata,
`ifdef APB_MEM_STRB_EN
    input  logic [DATA_WIDTH/8-1:0] Pstrb,
`endif
    output logic                    Pready,
    output logic                    Pslverr,
    output logic [DATA_WIDTH-1:0]   Prdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} >= (ADDR_WIDTH + 1)'(DEPTH);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic                  err_q;

    logic                  setup;
    logic                  addr_oor;
    logic                  do_write;
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx;

    assign addr_oor = out_of_range(Paddr);
    assign rd_idx   = Paddr[IDX_W-1:0];
    assign wr_idx   = addr_q[IDX_W-1:0];

    // A setup phase seen in WAIT restarts the transfer exactly like one seen in IDLE.
    assign setup    = Pselx && !Penable && (state == S_IDLE || state == S_WAIT);

    assign do_write = !Prst && (state == S_ACCESS) && Pselx && Penable && wr_q
                      && !out_of_range(addr_q);

    assign Pready   = (state == S_ACCESS);
    assign Pslverr  = (state == S_ACCESS) && err_q;

    always_ff @(posedge Pclk) begin
        if (Prst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            wr_q   <= 1'b0;
            err_q  <= 1'b0;
            Prdata <= '0;
        end else if (setup) begin
            addr_q <= Paddr;
            wr_q   <= Pwrite;
            err_q  <= addr_oor;
            // Read data is registered here so it is stable through WAIT and ACCESS.
            if (!Pwrite) begin
                Prdata <= addr_oor ? '0 : mem[rd_idx];
            end
            cnt    <= 4'(WAIT_STATES);
            state  <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end else begin
            case (state)
                S_WAIT: begin
                    if (!Pselx) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Storage has no reset so it maps onto RAM and survives Prst.
    always_ff @(posedge Pclk) begin
        if (do_write) begin
`ifdef APB_MEM_STRB_EN
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (Pstrb[i]) begin
                    mem[wr_idx][8*i +: 8] <= Pwdata[8*i +: 8];
                end
            end
`else
            mem[wr_idx] <= Pwdata;
`endif
        end
    end

endmodule
